// File: rtl/sensors_acquisition_pkg.sv
// Shared constants for the temperature monitor front end and its downstream summing stage.
package sensors_acquisition_pkg;

  localparam int unsigned SA_NUM_SENSORS = 5;
  localparam int unsigned SA_TEMP_W      = 8;
  localparam logic [7:0]  SA_MAX_TEMP    = 8'd125;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_NEXT   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Unsigned plausibility check of one reading against the ceiling.
  function automatic logic temp_plausible(input logic [7:0] value, input logic [7:0] max_temp);
    return value <= max_temp;
  endfunction

endpackage

// File: rtl/sensors_acquisition_timer.sv
// Per-sensor request timer: counts REQ cycles and flags the last allowed one.
module poll_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/sensors_acquisition.sv
// Polls the sensors one at a time, builds a scan in shadow registers and publishes it atomically.
module sensors_acquisition
  import sensors_acquisition_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = SA_NUM_SENSORS,
  parameter int unsigned TEMP_W      = SA_TEMP_W,
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [7:0]  MAX_TEMP    = SA_MAX_TEMP
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [NUM_SENSORS-1:0]        sensor_mask_i,
  output logic                          req_o,
  output logic [2:0]                    sel_o,
  input  logic                          ack_i,
  input  logic [TEMP_W-1:0]             data_i,
  output logic [NUM_SENSORS*TEMP_W-1:0] sensors_data_o,
  output logic [NUM_SENSORS-1:0]        sensors_en_o,
  output logic [NUM_SENSORS-1:0]        fault_o,
  output logic                          busy_o,
  output logic                          scan_done_o
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_SENSORS - 1);

  logic [1:0]                    state_q, state_d;
  logic [2:0]                    idx_q, idx_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [NUM_SENSORS*TEMP_W-1:0] data_q, data_d, sh_data_q, sh_data_d;
  logic [NUM_SENSORS-1:0]        en_q, en_d, sh_en_q, sh_en_d;
  logic [NUM_SENSORS-1:0]        fault_q, fault_d, sh_fault_q, sh_fault_d;
  logic                          tmr_clr, tmr_en, tmr_expired;
  logic                          req;

  poll_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_d     = data_q;
    en_d       = en_q;
    fault_d    = fault_q;
    sh_data_d  = sh_data_q;
    sh_en_d    = sh_en_q;
    sh_fault_d = sh_fault_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    req        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_REQ;
          idx_d   = '0;
          busy_d  = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_REQ: begin
        // Every polled slot rewrites all three shadow fields, so no clear is needed at scan start.
        if (!sensor_mask_i[idx_q]) begin
          sh_data_d[idx_q*TEMP_W +: TEMP_W] = '0;
          sh_en_d[idx_q]    = 1'b0;
          sh_fault_d[idx_q] = 1'b0;
          state_d           = ST_NEXT;
        end else begin
          req = 1'b1;
          if (ack_i) begin
            if (temp_plausible(data_i, MAX_TEMP)) begin
              sh_data_d[idx_q*TEMP_W +: TEMP_W] = data_i;
              sh_en_d[idx_q]    = 1'b1;
              sh_fault_d[idx_q] = 1'b0;
            end else begin
              sh_data_d[idx_q*TEMP_W +: TEMP_W] = '0;
              sh_en_d[idx_q]    = 1'b0;
              sh_fault_d[idx_q] = 1'b1;
            end
            state_d = ST_NEXT;
          end else if (tmr_expired) begin
            sh_data_d[idx_q*TEMP_W +: TEMP_W] = '0;
            sh_en_d[idx_q]    = 1'b0;
            sh_fault_d[idx_q] = 1'b1;
            state_d           = ST_NEXT;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_NEXT: begin
        tmr_clr = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_REQ;
        end
      end
      ST_COMMIT: begin
        data_d  = sh_data_q;
        en_d    = sh_en_q;
        fault_d = sh_fault_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      en_q       <= '0;
      fault_q    <= '0;
      sh_data_q  <= '0;
      sh_en_q    <= '0;
      sh_fault_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_q     <= data_d;
      en_q       <= en_d;
      fault_q    <= fault_d;
      sh_data_q  <= sh_data_d;
      sh_en_q    <= sh_en_d;
      sh_fault_q <= sh_fault_d;
    end
  end

  assign req_o          = req;
  assign sel_o          = idx_q;
  assign sensors_data_o = data_q;
  assign sensors_en_o   = en_q;
  assign fault_o        = fault_q;
  assign busy_o         = busy_q;
  assign scan_done_o    = done_q;

endmodule

// File: tb/tb_sensors_acquisition.sv
// Directed and randomized scans checked against a per-sensor outcome/latency model.
module tb_sensors_acquisition;

  localparam int unsigned TO   = 16;
  localparam int          MAXT = 125;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_i, start_i, ack_i;
  logic [4:0]  mask;
  logic [7:0]  data_i;
  logic        req_o, busy_o, scan_done_o;
  logic [2:0]  sel_o;
  logic [39:0] sensors_data_o;
  logic [4:0]  sensors_en_o, fault_o;

  int lat_a[5];
  int val_a[5];
  logic noise_en = 1'b0;
  int viol = 0;
  int vectors = 0;
  int miscompares = 0;

  sensors_acquisition #(.TIMEOUT(TO), .MAX_TEMP(8'd125)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .sensor_mask_i  (mask),
    .req_o          (req_o),
    .sel_o          (sel_o),
    .ack_i          (ack_i),
    .data_i         (data_i),
    .sensors_data_o (sensors_data_o),
    .sensors_en_o   (sensors_en_o),
    .fault_o        (fault_o),
    .busy_o         (busy_o),
    .scan_done_o    (scan_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outcome of each sensor and scan length in edges, from the per-sensor response times.
  function automatic void model(input logic [4:0] m, output logic [39:0] d,
                                output logic [4:0] en, output logic [4:0] f, output int lat);
    d = '0; en = '0; f = '0; lat = 1;
    for (int k = 0; k < 5; k++) begin
      if (!m[k]) lat += 2;
      else if (lat_a[k] < int'(TO)) begin
        lat += lat_a[k] + 2;
        if (val_a[k] <= MAXT) begin
          d[8*k +: 8] = 8'(val_a[k]);
          en[k] = 1'b1;
        end else f[k] = 1'b1;
      end else begin
        lat += int'(TO) + 1;
        f[k] = 1'b1;
      end
    end
  endfunction

  // Sensor responder: acks after lat_a[sel] request cycles; optional stray acks while req is low.
  initial begin
    int wcnt;
    wcnt = 0;
    ack_i = 1'b0;
    data_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        ack_i = 1'b0; wcnt = 0;
      end else if (req_o && sel_o < 3'd5) begin
        if (!mask[sel_o]) viol++;
        if (wcnt == lat_a[sel_o]) begin
          ack_i = 1'b1; data_i = 8'(val_a[sel_o]);
        end else begin
          ack_i = 1'b0; data_i = 8'($urandom);
        end
        wcnt++;
      end else begin
        wcnt = 0;
        ack_i = noise_en ? 1'($urandom) : 1'b0;
        data_i = 8'($urandom);
      end
    end
  end

  task automatic set_all(input int lat, input int v0, input int v1, input int v2, input int v3, input int v4);
    for (int k = 0; k < 5; k++) lat_a[k] = lat;
    val_a[0] = v0; val_a[1] = v1; val_a[2] = v2; val_a[3] = v3; val_a[4] = v4;
  endtask

  task automatic run_scan(input string tag, input logic [4:0] m, input logic pulse_extra);
    logic [39:0] ed; logic [4:0] een, ef; int elat, n, extra;
    model(m, ed, een, ef, elat);
    viol = 0;
    @(negedge clk);
    mask = m;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({tag, "_busy_start"}, 64'(busy_o), 64'd1);
    n = 0;
    while (n < 400 && !scan_done_o) begin
      @(posedge clk); #1;
      n++;
      if (pulse_extra && n == 3) start_i = 1'b1;
      if (pulse_extra && n == 4) start_i = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'(elat));
    chk({tag, "_data"}, 64'(sensors_data_o), 64'(ed));
    chk({tag, "_en"}, 64'(sensors_en_o), 64'(een));
    chk({tag, "_fault"}, 64'(fault_o), 64'(ef));
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_masked_req"}, 64'(viol), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(scan_done_o), 64'd0);
    if (pulse_extra) begin
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (scan_done_o || busy_o) extra++;
      end
      chk({tag, "_no_queued_scan"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int n, gap, r;
    logic [4:0] rm;
    rst_i = 1'b1; start_i = 1'b0; mask = '0;
    set_all(0, 20, 25, 30, 35, 40);
    #1;
    chk("reset_data", 64'(sensors_data_o), 64'd0);
    chk("reset_en", 64'(sensors_en_o), 64'd0);
    chk("reset_fault", 64'(fault_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(scan_done_o), 64'd0);
    chk("reset_req", 64'(req_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    run_scan("all_ack", 5'h1F, 1'b0);
    chk("all_ack_literal", 64'(sensors_data_o), 64'h28231E1914);
    noise_en = 1'b1;

    lat_a[2] = NEVER;
    run_scan("s2_timeout", 5'h1F, 1'b0);
    chk("s2_timeout_literal", 64'(sensors_data_o), 64'h2823001914);

    set_all(0, 20, 25, 30, 35, 200);
    run_scan("s4_range", 5'h1F, 1'b0);
    chk("s4_range_fault", 64'(fault_o), 64'h10);

    set_all(0, 20, 25, 30, 35, 40);
    run_scan("mask15", 5'h15, 1'b0);
    run_scan("pulse_start", 5'h1F, 1'b1);

    // Reset in the middle of sensor 3's request wipes the last published scan.
    @(negedge clk); mask = 5'h1F; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    n = 0;
    while (n < 100 && !(req_o && sel_o == 3'd3)) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_reach_s3", 64'(n < 100), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_data", 64'(sensors_data_o), 64'd0);
    chk("rst_mid_en", 64'(sensors_en_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_req", 64'(req_o), 64'd0);
    chk("rst_mid_sel", 64'(sel_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    set_all(1, 125, 126, 0, 124, 77);
    run_scan("post_rst", 5'h1F, 1'b0);

    // Held start: scans repeat with a single IDLE edge between them.
    set_all(0, 20, 25, 30, 35, 40);
    @(negedge clk); mask = 5'h1F; start_i = 1'b1;
    n = 0;
    while (n < 200 && !scan_done_o) begin
      @(posedge clk); #1; n++;
    end
    gap = 0;
    do begin
      @(posedge clk); #1; gap++;
    end while (gap < 200 && !scan_done_o);
    start_i = 1'b0;
    chk("b2b_gap", 64'(gap), 64'd12);
    chk("b2b_en", 64'(sensors_en_o), 64'h1F);
    @(posedge clk); #1;
    chk("b2b_stop_busy", 64'(busy_o), 64'd0);

    for (int s = 0; s < 40; s++) begin
      for (int k = 0; k < 5; k++) begin
        r = $urandom_range(0, 5);
        case (r)
          3: lat_a[k] = int'(TO) - 1;
          4: lat_a[k] = int'(TO);
          5: lat_a[k] = NEVER;
          default: lat_a[k] = r;
        endcase
        r = $urandom_range(0, 3);
        val_a[k] = (r == 0) ? $urandom_range(126, 255) :
                   (r == 1) ? $urandom_range(124, 127) : $urandom_range(0, 125);
      end
      rm = 5'($urandom);
      run_scan($sformatf("rand%0d", s), rm, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
